seq_lock_fsm: RTL

- Clocked, parametrised successor to the switch-driven sequence FSM and its display wrapper.
- Synchronises and edge-detects NUM_SW slide switches and checks switch presses against a programmable code of SEQ_LEN entries.
- Adds an inactivity timeout, a failure counter and a timed lockout.
- Outputs state, status flags Z, a 4-character ASCII message (fed to the existing ASCII-to-7-segment decoders) and LED mirror bits.

---
 rtl/seq_lock_fsm.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/seq_lock_fsm.sv
// Switch-code lock: synchronises and edge-detects the switches, checks presses against CODE,
// and adds an idle timeout in PROG, a failure counter and a timed lockout.
module seq_lock_fsm #(
    parameter int unsigned NUM_SW      = 5,
    parameter int unsigned SEQ_LEN     = 4,
    parameter logic [31:0] CODE        = 32'h0000_02D1,
    parameter int unsigned TIMEOUT_CYC = 50_000_000,
    parameter int unsigned MAX_FAILS   = 3,
    parameter int unsigned LOCK_CYC    = 250_000_000
) (
    input  logic              CLK,
    input  logic              KEY0,
    input  logic [NUM_SW-1:0] SW,
    output logic [2:0]        STATE,
    output logic [3:0]        PROG_IDX,
    output logic [3:0]        FAIL_CNT,
    output logic [1:0]        Z,
    output logic [31:0]       MSG,
    output logic [NUM_SW+1:0] LED_SW
);
    // state | meaning
    // CLEAR | idle, waiting for the first code entry
    // PROG  | PROG_IDX entries matched, idle timer running
    // OPEN  | full code matched, only SW0 clears it
    // ERR   | last entry was wrong, FAIL_CNT below MAX_FAILS
    // LOCK  | MAX_FAILS reached, switches ignored for LOCK_CYC cycles

    localparam int unsigned    IDX_W    = $clog2(NUM_SW);
    localparam int unsigned    TO_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam int unsigned    LK_W     = $clog2(LOCK_CYC) + 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [LK_W-1:0] LK_LAST  = LK_W'(LOCK_CYC - 1);
    localparam logic [3:0]      IDX_LAST = 4'(SEQ_LEN - 1);
    localparam logic [3:0]      FAIL_MAX = 4'(MAX_FAILS);

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_PROG  = 3'd1,
        S_OPEN  = 3'd2,
        S_ERR   = 3'd3,
        S_LOCK  = 3'd4
    } state_t;

    typedef enum logic [1:0] {EV_NONE, EV_CLR, EV_WRONG, EV_RIGHT} ev_t;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [NUM_SW-1:0] sync1, sync2, prev, press;
    logic [3:0]        hits;
    logic [IDX_W-1:0]  hit_idx, code_now;
    ev_t               ev;

    state_t            state, state_nx;
    logic [3:0]        prog_idx, idx_nx, fail_cnt, fail_nx, fail_inc;
    logic [TO_W-1:0]   idle_cnt, idle_nx;
    logic [LK_W-1:0]   lock_cnt, lock_nx;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge CLK or negedge KEY0) begin
        if (!KEY0) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end
    assign press = sync2 & ~prev;

    always_comb begin
        hits    = '0;
        hit_idx = '0;
        for (int i = 1; i < NUM_SW; i++) begin
            if (press[i]) begin
                hits    = hits + 4'd1;
                hit_idx = IDX_W'(i);
            end
        end
        code_now = CODE[prog_idx*IDX_W +: IDX_W];
        ev = EV_NONE;
        if (press[0])          ev = EV_CLR;
        else if (hits > 4'd1)  ev = EV_WRONG;
        else if (hits == 4'd1) ev = (hit_idx == code_now) ? EV_RIGHT : EV_WRONG;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_CLEAR;
            prog_idx <= '0;
            fail_cnt <= '0;
            idle_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            state    <= state_nx;
            prog_idx <= idx_nx;
            fail_cnt <= fail_nx;
            idle_cnt <= idle_nx;
            lock_cnt <= lock_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = prog_idx;
        fail_nx  = fail_cnt;
        idle_nx  = '0;
        lock_nx  = '0;
        fail_inc = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 4'd1;
        case (state)
            S_CLEAR, S_PROG, S_ERR: begin
                case (ev)
                    EV_CLR: begin
                        state_nx = S_CLEAR;
                        idx_nx   = '0;
                    end
                    EV_WRONG: begin
                        idx_nx   = '0;
                        fail_nx  = fail_inc;
                        state_nx = (fail_inc == FAIL_MAX) ? S_LOCK : S_ERR;
                    end
                    EV_RIGHT: begin
                        if (prog_idx == IDX_LAST) begin
                            state_nx = S_OPEN;
                            idx_nx   = '0;
                            fail_nx  = '0;
                        end else begin
                            state_nx = S_PROG;
                            idx_nx   = prog_idx + 4'd1;
                        end
                    end
                    default: begin
                        if (state == S_PROG) begin
                            if (idle_cnt == TO_LAST) begin
                                state_nx = S_CLEAR;
                                idx_nx   = '0;
                            end else begin
                                idle_nx = idle_cnt + TO_W'(1);
                            end
                        end
                    end
                endcase
            end
            S_OPEN: begin
                if (ev == EV_CLR) state_nx = S_CLEAR;
            end
            S_LOCK: begin
                if (lock_cnt == LK_LAST) begin
                    state_nx = S_CLEAR;
                    fail_nx  = '0;
                end else begin
                    lock_nx = lock_cnt + LK_W'(1);
                end
            end
            default: begin
                state_nx = S_CLEAR;
                idx_nx   = '0;
                fail_nx  = '0;
            end
        endcase
    end

    always_comb begin
        Z   = 2'b00;
        MSG = "Clar";
        case (state)
            S_PROG: MSG = {"S_0", 8'h30 + {4'h0, prog_idx}};
            S_OPEN: begin
                Z   = 2'b01;
                MSG = "OPEn";
            end
            S_ERR: begin
                Z   = 2'b10;
                MSG = {"Err", 8'h30 + {4'h0, fail_cnt}};
            end
            S_LOCK: begin
                Z   = 2'b11;
                MSG = "LOCd";
            end
            default: begin
                Z   = 2'b00;
                MSG = "Clar";
            end
        endcase
    end

    assign STATE    = state;
    assign PROG_IDX = prog_idx;
    assign FAIL_CNT = fail_cnt;
    assign LED_SW   = {Z, sync2};
endmodule
